// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: register-programmed controller for the bidirectional pad ring.
// Holds the per-pad control registers, synchronises the pad inputs through a
// three-flop chain and latches enabled rising/falling edges into a
// write-1-to-clear status register that drives a level interrupt.
module gpio_pad_ctrl #(
  parameter int NUM_BIDIR_PADS = 18
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [3:0]                addr,
  input  logic [31:0]               wdata,
  input  logic                      we,
  input  logic                      re,
  output logic [31:0]               rdata,
  output logic                      rvalid,
  output logic                      irq,
  input  logic [NUM_BIDIR_PADS-1:0] bidir_in,
  output logic [NUM_BIDIR_PADS-1:0] bidir_out,
  output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
  output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
  output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
  output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pd
);

  localparam int N = NUM_BIDIR_PADS;

  // Register word indices.
  localparam logic [3:0] ADDR_OUT      = 4'd0;
  localparam logic [3:0] ADDR_OUT_SET  = 4'd1;
  localparam logic [3:0] ADDR_OUT_CLR  = 4'd2;
  localparam logic [3:0] ADDR_OE       = 4'd3;
  localparam logic [3:0] ADDR_IE       = 4'd4;
  localparam logic [3:0] ADDR_PU       = 4'd5;
  localparam logic [3:0] ADDR_PD       = 4'd6;
  localparam logic [3:0] ADDR_CS       = 4'd7;
  localparam logic [3:0] ADDR_SL       = 4'd8;
  localparam logic [3:0] ADDR_IN       = 4'd9;
  localparam logic [3:0] ADDR_RISE_EN  = 4'd10;
  localparam logic [3:0] ADDR_FALL_EN  = 4'd11;
  localparam logic [3:0] ADDR_IRQ_STAT = 4'd12;

  // Write data trimmed to the pad count; upper bits are don't-care.
  logic [N-1:0] wr_data;
  assign wr_data = wdata[N-1:0];

  if (N < 32) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^wdata[31:N];
  end

  // Control registers.
  logic [N-1:0] out_q,     out_d;
  logic [N-1:0] oe_q,      oe_d;
  logic [N-1:0] ie_q,      ie_d;
  logic [N-1:0] pu_q,      pu_d;
  logic [N-1:0] pd_q,      pd_d;
  logic [N-1:0] cs_q,      cs_d;
  logic [N-1:0] sl_q,      sl_d;
  logic [N-1:0] rise_en_q, rise_en_d;
  logic [N-1:0] fall_en_q, fall_en_d;

  // Input synchroniser chain and edge status.
  logic [N-1:0] s1_q, s1_d;
  logic [N-1:0] s2_q, s2_d;
  logic [N-1:0] s3_q, s3_d;
  logic [N-1:0] irq_stat_q, irq_stat_d;

  // Read port.
  logic [31:0]  rdata_q, rdata_d;
  logic         rvalid_q, rvalid_d;

  // Edge detection terms.
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [N-1:0] w1c;

  // Register write decode: each register holds unless addressed by a write.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise a latch is inferred.
    out_d     = out_q;
    oe_d      = oe_q;
    ie_d      = ie_q;
    pu_d      = pu_q;
    pd_d      = pd_q;
    cs_d      = cs_q;
    sl_d      = sl_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    if (we) begin
      unique case (addr)
        ADDR_OUT:     out_d     = wr_data;
        ADDR_OUT_SET: out_d     = out_q | wr_data;
        ADDR_OUT_CLR: out_d     = out_q & ~wr_data;
        ADDR_OE:      oe_d      = wr_data;
        ADDR_IE:      ie_d      = wr_data;
        ADDR_PU:      pu_d      = wr_data;
        ADDR_PD:      pd_d      = wr_data;
        ADDR_CS:      cs_d      = wr_data;
        ADDR_SL:      sl_d      = wr_data;
        ADDR_RISE_EN: rise_en_d = wr_data;
        ADDR_FALL_EN: fall_en_d = wr_data;
        default:      ;
      endcase
    end
  end

  // Synchroniser shift: s1 captures the asynchronous pad, s2 is the stable
  // value software sees, s3 is the previous stable value for edge detection.
  always_comb begin
    s1_d = bidir_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Edge status: a freshly detected edge is OR-ed in after the W1C mask, so a
  // same-cycle edge survives a clear of its own bit.
  always_comb begin
    rise       = s2_q & ~s3_q & ie_q & rise_en_q;
    fall       = ~s2_q & s3_q & ie_q & fall_en_q;
    w1c        = (we && addr == ADDR_IRQ_STAT) ? wr_data : '0;
    irq_stat_d = (irq_stat_q & ~w1c) | rise | fall;
  end

  // Read mux: sampled from current flop values, so a same-cycle write is not
  // yet visible; rdata holds between reads.
  always_comb begin
    logic [N-1:0] rd_val;
    rd_val = '0;
    unique case (addr)
      ADDR_OUT:      rd_val = out_q;
      ADDR_OE:       rd_val = oe_q;
      ADDR_IE:       rd_val = ie_q;
      ADDR_PU:       rd_val = pu_q;
      ADDR_PD:       rd_val = pd_q;
      ADDR_CS:       rd_val = cs_q;
      ADDR_SL:       rd_val = sl_q;
      ADDR_IN:       rd_val = s2_q;
      ADDR_RISE_EN:  rd_val = rise_en_q;
      ADDR_FALL_EN:  rd_val = fall_en_q;
      ADDR_IRQ_STAT: rd_val = irq_stat_q;
      default:       rd_val = '0;
    endcase
    rdata_d  = rdata_q;
    rvalid_d = re;
    if (re) begin
      rdata_d         = '0;
      rdata_d[N-1:0]  = rd_val;
    end
  end

  // State registers; IE comes out of reset fully enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      out_q      <= '0;
      oe_q       <= '0;
      ie_q       <= '1;
      pu_q       <= '0;
      pd_q       <= '0;
      cs_q       <= '0;
      sl_q       <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      irq_stat_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      out_q      <= out_d;
      oe_q       <= oe_d;
      ie_q       <= ie_d;
      pu_q       <= pu_d;
      pd_q       <= pd_d;
      cs_q       <= cs_d;
      sl_q       <= sl_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      irq_stat_q <= irq_stat_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  // Pad controls straight from the registers; pull-up overrides pull-down.
  assign bidir_out = out_q;
  assign bidir_oe  = oe_q;
  assign bidir_cs  = cs_q;
  assign bidir_sl  = sl_q;
  assign bidir_ie  = ie_q;
  assign bidir_pu  = pu_q;
  assign bidir_pd  = pd_q & ~pu_q;

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign irq    = |irq_stat_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Testbench for gpio_pad_ctrl: directed scenarios plus a randomized run
// against a register-level reference model.
module tb_gpio_pad_ctrl;

  localparam int N = 18;
  localparam logic [31:0] MASK = 32'h0003_FFFF;

  logic          clk;
  logic          rst_n;
  logic [3:0]    addr;
  logic [31:0]   wdata;
  logic          we;
  logic          re;
  logic [31:0]   rdata;
  logic          rvalid;
  logic          irq;
  logic [N-1:0]  bidir_in;
  logic [N-1:0]  bidir_out, bidir_oe, bidir_cs, bidir_sl;
  logic [N-1:0]  bidir_ie, bidir_pu, bidir_pd;

  int checks;
  int failures;

  gpio_pad_ctrl #(.NUM_BIDIR_PADS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .re        (re),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .irq       (irq),
    .bidir_in  (bidir_in),
    .bidir_out (bidir_out),
    .bidir_oe  (bidir_oe),
    .bidir_cs  (bidir_cs),
    .bidir_sl  (bidir_sl),
    .bidir_ie  (bidir_ie),
    .bidir_pu  (bidir_pu),
    .bidir_pd  (bidir_pd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, output logic [31:0] d);
    addr = a;
    re   = 1'b1;
    tick();
    re   = 1'b0;
    d    = rdata;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    we = 1'b0; re = 1'b0; addr = '0; wdata = '0; bidir_in = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    apply_reset();
    checks++;
    if (irq !== 1'b0 || rvalid !== 1'b0 || rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_port: irq=%b rvalid=%b rdata=%h required 0 0 0", irq, rvalid, rdata);
    end
    checks++;
    if (bidir_oe !== '0 || bidir_ie !== '1 || bidir_pu !== '0 || bidir_pd !== '0 || bidir_out !== '0) begin
      failures++;
      $display("FAIL reset_pads: oe=%h ie=%h pu=%h pd=%h out=%h required 0 3ffff 0 0 0",
               bidir_oe, bidir_ie, bidir_pu, bidir_pd, bidir_out);
    end
    do_read(4'd3, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_oe_read: got %h required 0", d); end
    checks++;
    if (rvalid !== 1'b1) begin failures++; $display("FAIL reset_rvalid: got %b required 1", rvalid); end
    do_read(4'd4, d);
    checks++;
    if (d !== 32'h0003_FFFF) begin failures++; $display("FAIL reset_ie_read: got %h required 3ffff", d); end
    tick();
    checks++;
    if (rvalid !== 1'b0 || rdata !== 32'h0003_FFFF) begin
      failures++;
      $display("FAIL rvalid_pulse: rvalid=%b rdata=%h required 0 3ffff", rvalid, rdata);
    end
    for (int a = 13; a < 16; a++) begin
      do_write(4'(a), 32'hFFFF_FFFF);
      do_read(4'(a), d);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL unmapped_read_%0d: got %h required 0", a, d); end
    end
  endtask

  task automatic test_out_ops();
    logic [31:0] d;
    do_write(4'd0, 32'h0000_00F0);
    checks++;
    if (bidir_out !== 18'h000F0) begin failures++; $display("FAIL out_write: got %h required 000f0", bidir_out); end
    do_write(4'd1, 32'h0000_0003);
    checks++;
    if (bidir_out !== 18'h000F3) begin failures++; $display("FAIL out_set: got %h required 000f3", bidir_out); end
    do_write(4'd2, 32'h0000_0010);
    checks++;
    if (bidir_out !== 18'h000E3) begin failures++; $display("FAIL out_clr: got %h required 000e3", bidir_out); end
    do_read(4'd0, d);
    checks++;
    if (d !== 32'h0000_00E3) begin failures++; $display("FAIL out_read: got %h required e3", d); end
    do_read(4'd1, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL out_set_read: got %h required 0", d); end
    // Upper write-data bits are ignored.
    do_write(4'd0, 32'hFFFF_FFFF);
    do_read(4'd0, d);
    checks++;
    if (d !== 32'h0003_FFFF) begin failures++; $display("FAIL out_upper_bits: got %h required 3ffff", d); end
    // Same-cycle write and read: read returns the pre-write value.
    addr = 4'd0; wdata = 32'h0000_0055; we = 1'b1; re = 1'b1;
    tick();
    we = 1'b0; re = 1'b0;
    checks++;
    if (rdata !== 32'h0003_FFFF || bidir_out !== 18'h00055) begin
      failures++;
      $display("FAIL rw_same_cycle: rdata=%h out=%h required 3ffff 00055", rdata, bidir_out);
    end
    do_write(4'd0, 32'h0);
  endtask

  task automatic test_pulls();
    logic [31:0] d;
    do_write(4'd5, 32'h1);
    do_write(4'd6, 32'h3);
    checks++;
    if (bidir_pu !== 18'h1 || bidir_pd !== 18'h2) begin
      failures++;
      $display("FAIL pull_conflict: pu=%h pd=%h required 1 2", bidir_pu, bidir_pd);
    end
    do_read(4'd6, d);
    checks++;
    if (d !== 32'h3) begin failures++; $display("FAIL pd_readback: got %h required 3", d); end
    do_write(4'd5, 32'h0);
    do_write(4'd6, 32'h0);
  endtask

  task automatic test_rise_irq();
    logic [31:0] d;
    do_write(4'd10, 32'h4);
    bidir_in[2] = 1'b1;
    tick();                       // edge k samples the new pad value
    do_read(4'd9, d);             // edge k+1: returns IN as it was before k+1
    checks++;
    if (d[2] !== 1'b0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL rise_k1: in2=%b irq=%b required 0 0", d[2], irq);
    end
    do_read(4'd9, d);             // edge k+2: IN already 1 since k+1
    checks++;
    if (d[2] !== 1'b1) begin failures++; $display("FAIL rise_in_visible: got %b required 1", d[2]); end
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL rise_irq: got %b required 1", irq); end
    do_write(4'd12, 32'h4);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL rise_w1c: got %b required 0", irq); end
    bidir_in[2] = 1'b0;
    repeat (5) tick();
    do_read(4'd12, d);
    checks++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL fall_no_status: stat=%h irq=%b required 0 0", d, irq);
    end
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    do_write(4'd11, 32'h1);
    bidir_in[0] = 1'b1;
    repeat (5) tick();
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL pin0_rise_disabled: irq=%b required 0", irq); end
    bidir_in[0] = 1'b0;
    tick();                       // edge k
    tick();                       // edge k+1: fall now detected combinationally
    do_write(4'd12, 32'h1);       // edge k+2: W1C collides with the new fall
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL set_wins_irq: got %b required 1", irq); end
    do_read(4'd12, d);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL set_wins_stat: got %h required 1", d); end
    do_write(4'd12, 32'h1);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL set_wins_clear: got %b required 0", irq); end
    do_write(4'd11, 32'h0);
  endtask

  task automatic test_ie_gating_and_reset();
    logic [31:0] d;
    do_write(4'd4, 32'h0003_FFDF);
    do_write(4'd10, 32'h24);
    do_write(4'd11, 32'h20);
    bidir_in[5] = 1'b1;
    repeat (4) tick();
    bidir_in[5] = 1'b0;
    repeat (4) tick();
    do_read(4'd12, d);
    checks++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL ie_gating: stat=%h irq=%b required 0 0", d, irq);
    end
    bidir_in[2] = 1'b1;
    repeat (4) tick();
    do_write(4'd10, 32'h0);       // disabling must not clear latched status
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL enable_clear_keeps: irq=%b required 1", irq); end
    do_write(4'd3, 32'hFF);
    do_read(4'd9, d);
    checks++;
    if (rvalid !== 1'b1 || bidir_oe !== 18'hFF) begin
      failures++;
      $display("FAIL pre_reset: rvalid=%b oe=%h required 1 ff", rvalid, bidir_oe);
    end
    #2 rst_n = 1'b0;              // asserted between clock edges
    #1;
    checks++;
    if (irq !== 1'b0 || bidir_oe !== '0 || rvalid !== 1'b0 || bidir_ie !== '1) begin
      failures++;
      $display("FAIL async_reset: irq=%b oe=%h rvalid=%b ie=%h required 0 0 0 3ffff",
               irq, bidir_oe, rvalid, bidir_ie);
    end
    repeat (2) tick();
    rst_n = 1'b1;                 // pad 2 still high: must not raise an irq
    repeat (5) tick();
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL post_reset_spurious: irq=%b required 0", irq); end
    bidir_in = '0;
    repeat (4) tick();
  endtask

  // Reference model: register file indexed by word address plus a history
  // of the pad values sampled at the last three edges.
  logic [31:0] m_reg [16];
  logic [31:0] m_hist [3];
  logic [31:0] m_stat;
  logic [31:0] m_rdata;
  logic        m_rvalid;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = 32'h0;
    m_reg[4] = MASK;
    for (int i = 0; i < 3; i++) m_hist[i] = 32'h0;
    m_stat = 32'h0; m_rdata = 32'h0; m_rvalid = 1'b0;
  endtask

  task automatic model_edge(input logic w, input logic r, input logic [3:0] a,
                            input logic [31:0] wd_in, input logic [31:0] pads);
    logic [31:0] wd, rise_m, fall_m, stable, prev;
    wd     = wd_in & MASK;
    stable = m_hist[1];
    prev   = m_hist[2];
    rise_m = stable & ~prev & m_reg[4] & m_reg[10];
    fall_m = ~stable & prev & m_reg[4] & m_reg[11];
    m_rvalid = r;
    if (r) begin
      case (a)
        4'd0, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10, 4'd11: m_rdata = m_reg[a];
        4'd9:    m_rdata = stable;
        4'd12:   m_rdata = m_stat;
        default: m_rdata = 32'h0;
      endcase
    end
    if (w && a == 4'd12) m_stat = (m_stat & ~wd) | rise_m | fall_m;
    else                 m_stat = m_stat | rise_m | fall_m;
    if (w) begin
      case (a)
        4'd0, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10, 4'd11: m_reg[a] = wd;
        4'd1:    m_reg[0] = m_reg[0] | wd;
        4'd2:    m_reg[0] = m_reg[0] & ~wd;
        default: ;
      endcase
    end
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = pads & MASK;
  endtask

  task automatic test_random();
    logic [125:0] exp_pads, got_pads;
    apply_reset();
    model_reset();
    for (int i = 0; i < 600; i++) begin
      we    = 1'($urandom_range(0, 1));
      re    = 1'($urandom_range(0, 1));
      addr  = ($urandom_range(0, 3) == 0) ? 4'd12 : 4'($urandom_range(0, 15));
      wdata = $urandom;
      if ($urandom_range(0, 3) == 0) bidir_in = N'($urandom);
      @(posedge clk);
      model_edge(we, re, addr, wdata, {14'h0, bidir_in});
      #1;
      exp_pads = {m_reg[0][17:0], m_reg[3][17:0], m_reg[4][17:0], m_reg[5][17:0],
                  m_reg[6][17:0] & ~m_reg[5][17:0], m_reg[7][17:0], m_reg[8][17:0]};
      got_pads = {bidir_out, bidir_oe, bidir_ie, bidir_pu, bidir_pd, bidir_cs, bidir_sl};
      checks++;
      if (got_pads !== exp_pads) begin
        failures++;
        $display("FAIL rand_pads[%0d]: got %h required %h", i, got_pads, exp_pads);
      end
      checks++;
      if (irq !== (m_stat != 32'h0) || rvalid !== m_rvalid) begin
        failures++;
        $display("FAIL rand_irq_rvalid[%0d]: irq=%b rvalid=%b required %b %b",
                 i, irq, rvalid, (m_stat != 32'h0), m_rvalid);
      end
      checks++;
      if (rdata !== m_rdata) begin
        failures++;
        $display("FAIL rand_rdata[%0d]: got %h required %h", i, rdata, m_rdata);
      end
    end
    we = 1'b0; re = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    we = 1'b0; re = 1'b0; addr = '0; wdata = '0; bidir_in = '0;
    test_reset();
    test_out_ops();
    test_pulls();
    test_rise_irq();
    test_set_wins();
    test_ie_gating_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_pad_ctrl.md
# gpio_pad_ctrl

Register-programmed GPIO controller inside `chip_core`, directly upstream/downstream of the bidirectional pad ring. It drives every per-pad control signal (`out`, `oe`, `cs`, `sl`, `ie`, `pu`, `pd`) from software-visible registers. It also synchronises the pad inputs and raises a level interrupt on enabled rising or falling edges. Firmware reaches it through a simple single-cycle register port.

## Interface
Parameters:
- `NUM_BIDIR_PADS`, default 18: number of controlled pads, legal range 1..32.

Ports:
- `clk`, in, 1: core clock. The block uses this single clock only.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `addr`, in, 4: word index of the register.
- `wdata`, in, 32: write data. Bits at index `NUM_BIDIR_PADS` and above are ignored.
- `we`, in, 1: write strobe, one cycle.
- `re`, in, 1: read strobe, one cycle.
- `rdata`, out, 32: read data. Bits at index `NUM_BIDIR_PADS` and above read 0.
- `rvalid`, out, 1: one-cycle pulse marking `rdata` valid.
- `irq`, out, 1: level interrupt.
- `bidir_in`, in, N: pad Y inputs, asynchronous to `clk`.
- `bidir_out`, `bidir_oe`, `bidir_cs`, `bidir_sl`, `bidir_ie`, `bidir_pu`, `bidir_pd`, out, N each: per-pad controls.

## Operation
Register map (word index):
- 0 OUT: RW.
- 1 OUT_SET: WO, OUT |= wdata.
- 2 OUT_CLR: WO, OUT &= ~wdata.
- 3 OE: RW.
- 4 IE: RW.
- 5 PU: RW.
- 6 PD: RW.
- 7 CS: RW.
- 8 SL: RW.
- 9 IN: RO, synchronised pad value.
- 10 RISE_EN: RW.
- 11 FALL_EN: RW.
- 12 IRQ_STAT: write-1-to-clear.
- 13..15: reads return 0; writes have no effect.

Access rules:
- A write to a read-only or write-only register is a no-op on the read side. Reads of OUT_SET and OUT_CLR return 0.
- `we` and `re` asserted in the same cycle: the write is performed and the read returns the pre-write value.

Pad controls:
- Outputs map register bits directly, except `bidir_pd = PD & ~PU`. Pull-up wins if both are set; the PD register itself still reads back as written.

Input path:
- Three flops per pad: `s1 <= bidir_in`, `s2 <= s1`, `s3 <= s2`. IN reads `s2`.

Edge detection:
- `rise = s2 & ~s3 & IE & RISE_EN`.
- `fall = ~s2 & s3 & IE & FALL_EN`.
- Each cycle, `IRQ_STAT <= (IRQ_STAT & ~w1c) | rise | fall`.
- A new edge in the same cycle as a W1C of that bit leaves the bit set (set wins).

Interrupt and enables:
- `irq = |IRQ_STAT`, driven combinationally from the flops.
- Clearing RISE_EN or FALL_EN does not clear already-latched status bits.

Reset values:
- OUT, OE, PU, PD, CS, SL, RISE_EN, FALL_EN, IRQ_STAT and s1/s2/s3 all reset to 0.
- IE resets to all-ones.
- Resulting pads at reset: all inputs, input buffers enabled, no pulls.
- `rdata` = 0, `rvalid` = 0, `irq` = 0.

## Timing
- Write: registers update on the clock edge where `we` is high. Pad outputs reflect the new value immediately after that edge.
- Read: `re` high at edge n gives `rdata`/`rvalid` valid after edge n for exactly one cycle. `rdata` holds its value until the next read.
- Input latency: a `bidir_in` change sampled at edge k is visible in IN after edge k+1.
- Interrupt latency: for the same change, IRQ_STAT and `irq` assert after edge k+2.
- Back-to-back accesses every cycle are allowed; there are no stalls.
- Reset asserted mid-operation clears everything asynchronously. `irq` and all pad outputs drop without waiting for a clock.
- The first edge after release must not raise a spurious interrupt. This holds because s2 and s3 are both 0 at release.

## Test plan
- Reset defaults: after release, OE reads 0x0, IE reads 0x3FFFF, `bidir_oe` = 0, `bidir_ie` = all-ones, `irq` = 0, reads of 13..15 return 0.
- Atomic output ops: write OUT = 0x00F0, then OUT_SET 0x0003, then OUT_CLR 0x0010. Require OUT = 0x00E3 and `bidir_out` = 0x00E3 one cycle after each write.
- Pull conflict: write PU = 0x1 and PD = 0x3. Require `bidir_pu` = 0x1, `bidir_pd` = 0x2, and PD reads back 0x3.
- Rising-edge interrupt: set RISE_EN = 0x4, drive `bidir_in[2]` 0→1 sampled at edge k. Require IN bit 2 = 1 after k+1 and `irq` = 1 after k+2. A falling edge on pin 2 causes no new status. W1C 0x4 drops `irq` the next cycle.
- Set-wins collision: with FALL_EN = 0x1, time a W1C of bit 0 into the same cycle as a detected fall on pin 0. Require IRQ_STAT bit 0 to remain 1.
- IE gating and reset mid-irq: with IE bit 5 = 0 and both enables set, toggle pin 5 and require no status. Then latch an irq on another pin, assert `rst_n` low asynchronously between clocks, and require `irq`, OE and `rvalid` to be 0 at once.
